// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by the sequential ALU and its multiplier
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_SLT = 4'd6,
        OP_SLL = 4'd7,
        OP_SRL = 4'd8,
        OP_SRA = 4'd9,
        OP_MUL = 4'd10
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative unsigned multiplier, one partial-product step per clock
module shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic               w_last;

    // r_cnt counts finished steps minus one; bit 0 is folded into the start edge so the
    // full product is ready one cycle before the owner's WIDTH-th busy edge
    assign w_last  = r_cnt == CNT_W'(WIDTH - 1);
    assign done    = r_run && w_last;
    assign product = r_acc;

    // load on start, then add the shifted multiplicand for each remaining multiplier bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (start) begin
            r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            r_mplier <= b >> 1;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run && !w_last) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with valid/ready handshakes and an iterative multiply
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    src1,
    input  logic [WIDTH-1:0]    src2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                negative,
    output logic                carry,
    output logic                overflow,
    output logic                busy
);

    state_t               r_state;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic                 r_negative;
    logic                 r_carry;
    logic                 r_overflow;
    logic                 r_out_valid;

    alu_op_t              w_op;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_b;
    logic [WIDTH:0]       w_sum;
    logic                 w_arith_v;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_op      = alu_op_t'(op);
    assign w_shamt   = src2[SHAMT_W-1:0];
    // SUB is a + ~b + 1, so the carry-out doubles as the no-borrow flag
    assign w_b       = (w_op == OP_SUB) ? ~src2 : src2;
    assign w_sum     = {1'b0, src1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_op == OP_SUB};
    assign w_arith_v = (src1[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != src1[WIDTH-1]);

    assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && (w_op == OP_MUL);
    assign busy      = r_state == BUSY;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign carry     = r_carry;
    assign overflow  = r_overflow;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_start),
        .a       (src1),
        .b       (src2),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // single-cycle datapath; MUL and the illegal codes fall through to a zero result
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_arith_v;
            end
            OP_AND:  w_res = src1 & src2;
            OP_OR:   w_res = src1 | src2;
            OP_XOR:  w_res = src1 ^ src2;
            OP_NOR:  w_res = ~(src1 | src2);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
            OP_SLL:  w_res = src1 << w_shamt;
            OP_SRL:  w_res = src1 >> w_shamt;
            OP_SRA:  w_res = $unsigned($signed(src1) >>> w_shamt);
            default: w_res = '0;
        endcase
    end

    // control FSM and output registers; a held result is only replaced once it drains
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_start) begin
                    r_state <= BUSY;
                    r_cnt   <= '0;
                end else if (w_accept) begin
                    r_result    <= w_res;
                    r_zero      <= w_res == '0;
                    r_negative  <= w_res[WIDTH-1];
                    r_carry     <= w_c;
                    r_overflow  <= w_v;
                    r_out_valid <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == SHAMT_W'(WIDTH - 1) && w_mul_done) begin
                    r_state     <= IDLE;
                    r_result    <= w_prod[WIDTH-1:0];
                    r_zero      <= w_prod[WIDTH-1:0] == '0;
                    r_negative  <= w_prod[WIDTH-1];
                    r_carry     <= 1'b0;
                    r_overflow  <= |w_prod[2*WIDTH-1:WIDTH];
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed and randomized checks of alu_seq_unit against a behavioural model
module tb_alu_seq_unit;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, negative, carry, overflow, busy;

    int n_checks = 0;
    int n_pass = 0;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // reference: plain 64-bit arithmetic on the operand values
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, s;
        longint unsigned ua, ub, u;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sh = int'(b[4:0]);
        e = '0;
        case (o)
            4'd0: begin
                s = sa + sb; u = ua + ub;
                e.r = u[31:0]; e.c = u > 64'hFFFF_FFFF; e.v = s > MAXS || s < MINS;
            end
            4'd1: begin
                s = sa - sb;
                e.r = a - b; e.c = ua >= ub; e.v = s > MAXS || s < MINS;
            end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = ~(a | b);
            4'd6: e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: e.r = a << sh;
            4'd8: e.r = a >> sh;
            4'd9: begin s = sa >>> sh; e.r = s[31:0]; end
            4'd10: begin u = ua * ub; e.r = u[31:0]; e.v = u[63:32] != 0; end
            default: e.r = '0;
        endcase
        e.z = e.r == 0;
        e.n = e.r[31];
        return e;
    endfunction

    // present one op at a negedge, release after acceptance, wait (bounded) for out_valid
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output bit acc, output int lat, output int nbusy, output bit ir_bad,
                         output exp_t obs);
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        acc = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; nbusy = 0; ir_bad = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (busy) nbusy++;
            if (in_ready) ir_bad = 1;
        end
        obs = {result, zero, negative, carry, overflow};
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, busy, result, zero, negative, carry, overflow} !== 38'd0)
            $display("FAIL reset_state: got %h want 0", {out_valid, busy, result, zero, negative, carry, overflow});
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    logic [3:0]  d_op  [10] = '{4'd0, 4'd1, 4'd1, 4'd6, 4'd9, 4'd8, 4'd7, 4'd15, 4'd10, 4'd10};
    logic [31:0] d_a   [10] = '{32'h7FFFFFFF, 32'd5, 32'd3, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                32'd1, 32'h1234, 32'h00010000, 32'd7};
    logic [31:0] d_b   [10] = '{32'd1, 32'd5, 32'd5, 32'd1, 32'd4, 32'd4, 32'd33, 32'h5678, 32'h00010000, 32'd6};
    logic [31:0] d_res [10] = '{32'h80000000, 32'd0, 32'hFFFFFFFE, 32'd1, 32'hF8000000, 32'h08000000,
                                32'd2, 32'd0, 32'd0, 32'd42};

    task automatic test_directed();
        bit acc, irb;
        int lat, nb, wl, wb;
        exp_t obs, e;
        for (int i = 0; i < 10; i++) begin
            issue(d_op[i], d_a[i], d_b[i], acc, lat, nb, irb, obs);
            e = model(d_op[i], d_a[i], d_b[i]);
            // a MUL result appears on the 32nd edge after the accept edge: 32 busy samples, then valid
            wl = (d_op[i] == 4'd10) ? 33 : 1;
            wb = (d_op[i] == 4'd10) ? 32 : 0;
            n_checks++;
            if (acc !== 1'b1) $display("FAIL dir%0d_accept: in_ready %b want 1", i, acc);
            else n_pass++;
            n_checks++;
            if (obs.r !== d_res[i]) $display("FAIL dir%0d_result: got %h want %h", i, obs.r, d_res[i]);
            else n_pass++;
            n_checks++;
            if (obs[3:0] !== e[3:0]) $display("FAIL dir%0d_flags: got ZNCV=%b want %b", i, obs[3:0], e[3:0]);
            else n_pass++;
            n_checks++;
            if (lat !== wl || nb !== wb) $display("FAIL dir%0d_latency: got %0d/%0d busy want %0d/%0d", i, lat, nb, wl, wb);
            else n_pass++;
            n_checks++;
            if (irb !== 1'b0) $display("FAIL dir%0d_in_ready_busy: got 1 want 0", i);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] o;
        logic [31:0] a, b;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            o = 4'($urandom_range(0, 14));
            if (o >= 4'd10) o = o + 4'd1;
            a = $urandom; b = $urandom;
            op = o; src1 = a; src2 = b; in_valid = 1'b1;
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL b2b%0d_in_ready: got %b want 1", i, in_ready);
            else n_pass++;
            @(negedge clk);
            e = model(o, a, b);
            n_checks++;
            if (out_valid !== 1'b1 || {result, zero, negative, carry, overflow} !== e)
                $display("FAIL b2b%0d op%0d: got v=%b %h want v=1 %h", i, o, out_valid,
                         {result, zero, negative, carry, overflow}, e);
            else n_pass++;
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit acc, irb;
        int lat, nb;
        exp_t held, e;
        logic [31:0] a, b;
        out_ready = 1'b0;
        issue(4'd0, $urandom, $urandom, acc, lat, nb, irb, held);
        n_checks++;
        if (acc !== 1'b1 || lat !== 1) $display("FAIL bp_first: accept %b lat %0d want 1/1", acc, lat);
        else n_pass++;
        a = $urandom; b = $urandom;
        op = 4'd1; src1 = a; src2 = b; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {result, zero, negative, carry, overflow} !== held)
                $display("FAIL bp_hold%0d: v=%b rdy=%b %h want v=1 rdy=0 %h", i, out_valid, in_ready,
                         {result, zero, negative, carry, overflow}, held);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        e = model(4'd1, a, b);
        n_checks++;
        if (out_valid !== 1'b1 || {result, zero, negative, carry, overflow} !== e)
            $display("FAIL bp_replace: v=%b %h want v=1 %h", out_valid, {result, zero, negative, carry, overflow}, e);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain: out_valid %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        bit acc, irb;
        int lat, nb, wl;
        logic [3:0] o;
        logic [31:0] a, b;
        exp_t obs, e;
        for (int i = 0; i < 30; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 2) == 0) a = a & 32'h0000FFFF;
            if ($urandom_range(0, 2) == 0) b = b & 32'h0000FFFF;
            issue(o, a, b, acc, lat, nb, irb, obs);
            e = model(o, a, b);
            wl = (o == 4'd10) ? 33 : 1;
            n_checks++;
            if (acc !== 1'b1 || lat !== wl || obs !== e)
                $display("FAIL rnd%0d op%0d a=%h b=%h: acc=%b lat=%0d %h want acc=1 lat=%0d %h",
                         i, o, a, b, acc, lat, obs, wl, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mul();
        bit acc, irb;
        int lat, nb, seen;
        logic [31:0] a, b;
        exp_t obs, e;
        @(negedge clk);
        op = 4'd10; src1 = $urandom | 32'h1; src2 = $urandom | 32'h1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mulrst_busy_before: got %b want 1", busy);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0)
            $display("FAIL mulrst_abort: v=%b busy=%b res=%h want 0/0/0", out_valid, busy, result);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL mulrst_in_ready: got %b want 1", in_ready);
        else n_pass++;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL mulrst_no_result: out_valid seen %0d cycles want 0", seen);
        else n_pass++;
        a = $urandom; b = $urandom;
        issue(4'd0, a, b, acc, lat, nb, irb, obs);
        e = model(4'd0, a, b);
        n_checks++;
        if (acc !== 1'b1 || lat !== 1 || obs !== e)
            $display("FAIL mulrst_add: acc=%b lat=%0d %h want 1/1 %h", acc, lat, obs, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
